// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I instruction-fetch stage.
package rv32i_pkg;

    // ADDI x0,x0,0: what decode sees whenever no real instruction is offered.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Sequential fetch step; instructions are one 32-bit word.
    localparam logic [31:0] PC_INC = 32'd4;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,  // request outstanding at the current pc
        ST_BLOCKED = 2'd1,  // output and skid both full, no request
        ST_DISCARD = 2'd2,  // waiting out a stale response after a redirect
        ST_FAULT   = 2'd3   // misaligned target presented, fetch parked
    } fetch_state_e;

    // A fetch target is usable only if it is word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/rv32i_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus decode handshake.
interface rv32i_fetch_if;
    logic [31:0] o_iaddr;
    logic        o_stb_inst;
    logic        i_ack_inst;
    logic [31:0] i_inst_mem;
    logic        i_stall;
    logic        i_change_pc;
    logic [31:0] i_new_pc;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        o_valid;
    logic        o_misaligned;

    // Fetch stage side.
    modport master (
        output o_iaddr, o_stb_inst, o_inst, o_pc, o_valid, o_misaligned,
        input  i_ack_inst, i_inst_mem, i_stall, i_change_pc, i_new_pc
    );

    // Memory / decode / redirect side.
    modport slave (
        input  o_iaddr, o_stb_inst, o_inst, o_pc, o_valid, o_misaligned,
        output i_ack_inst, i_inst_mem, i_stall, i_change_pc, i_new_pc
    );
endinterface

// File: rtl/rv32i_fetch_skid.sv
// One-entry {pc, inst} holding register that absorbs a response arriving
// while decode is stalled. Clear beats load, load beats drain.
module rv32i_fetch_skid (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_drain,
    input  logic        i_clear,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    output logic        o_full,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst
);

    logic        r_full;
    logic [31:0] r_pc;
    logic [31:0] r_inst;

    // Entry storage and occupancy flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_full <= 1'b0;
            r_pc   <= 32'h0000_0000;
            r_inst <= 32'h0000_0000;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_pc   <= i_pc;
            r_inst <= i_inst;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_pc   = r_pc;
    assign o_inst = r_inst;

endmodule

// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch: owns the PC, issues word reads, hands
// {inst, pc} to decode through a registered output with a 1-entry skid,
// and handles redirects including dropping a stale in-flight response.
module rv32i_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = rv32i_pkg::NOP_INST
) (
    input  logic          i_clk,
    input  logic          i_rst,
    rv32i_fetch_if.master bus
);
    import rv32i_pkg::*;

    fetch_state_e r_state, w_state_next;
    logic [31:0]  r_pc, w_pc_next;
    logic         r_stb, w_stb_next;
    logic [31:0]  r_iaddr, w_iaddr_next;
    logic         r_out_valid, w_out_valid_next;
    logic [31:0]  r_out_inst, w_out_inst_next;
    logic [31:0]  r_out_pc, w_out_pc_next;
    logic         r_out_mis, w_out_mis_next;

    logic         w_skid_load, w_skid_drain, w_skid_clear;
    logic         w_skid_full;
    logic [31:0]  w_skid_pc, w_skid_inst;

    logic         w_ack, w_pending, w_out_free;
    logic [31:0]  w_pc_inc;

    // A response only counts while our strobe is up; a late ack after reset is ignored.
    assign w_ack      = r_stb & bus.i_ack_inst;
    assign w_pending  = r_stb & ~bus.i_ack_inst;
    assign w_out_free = ~r_out_valid | ~bus.i_stall;
    assign w_pc_inc   = r_pc + PC_INC;

    rv32i_fetch_skid u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_clear (w_skid_clear),
        .i_pc    (r_pc),
        .i_inst  (bus.i_inst_mem),
        .o_full  (w_skid_full),
        .o_pc    (w_skid_pc),
        .o_inst  (w_skid_inst)
    );

    // State, PC, bus request and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_REQ;
            r_pc        <= PC_RESET;
            r_stb       <= 1'b0;
            r_iaddr     <= PC_RESET;
            r_out_valid <= 1'b0;
            r_out_inst  <= NOP_INST;
            r_out_pc    <= 32'h0000_0000;
            r_out_mis   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_stb       <= w_stb_next;
            r_iaddr     <= w_iaddr_next;
            r_out_valid <= w_out_valid_next;
            r_out_inst  <= w_out_inst_next;
            r_out_pc    <= w_out_pc_next;
            r_out_mis   <= w_out_mis_next;
        end
    end

    // Next-state, PC and output-register logic; redirect overrides everything.
    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_stb_next       = r_stb;
        w_iaddr_next     = r_iaddr;
        w_out_valid_next = r_out_valid;
        w_out_inst_next  = r_out_inst;
        w_out_pc_next    = r_out_pc;
        w_out_mis_next   = r_out_mis;
        w_skid_load      = 1'b0;
        w_skid_drain     = 1'b0;
        w_skid_clear     = 1'b0;

        if (bus.i_change_pc) begin
            w_pc_next        = bus.i_new_pc;
            w_out_valid_next = 1'b0;
            w_out_inst_next  = NOP_INST;
            w_out_mis_next   = 1'b0;
            w_skid_clear     = 1'b1;
            if (w_pending) begin
                // Keep the old address on the bus until its response drains.
                w_state_next = ST_DISCARD;
                w_stb_next   = 1'b1;
            end else if (is_misaligned(bus.i_new_pc)) begin
                w_state_next     = ST_FAULT;
                w_stb_next       = 1'b0;
                w_out_valid_next = 1'b1;
                w_out_mis_next   = 1'b1;
                w_out_pc_next    = bus.i_new_pc;
            end else begin
                w_state_next = ST_REQ;
                w_stb_next   = 1'b1;
                w_iaddr_next = bus.i_new_pc;
            end
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (w_ack) begin
                        w_pc_next    = w_pc_inc;
                        w_iaddr_next = w_pc_inc;
                        if (w_out_free) begin
                            w_out_valid_next = 1'b1;
                            w_out_inst_next  = bus.i_inst_mem;
                            w_out_pc_next    = r_pc;
                            w_stb_next       = 1'b1;
                        end else begin
                            w_skid_load  = 1'b1;
                            w_state_next = ST_BLOCKED;
                            w_stb_next   = 1'b0;
                        end
                    end else begin
                        w_stb_next   = 1'b1;
                        w_iaddr_next = r_pc;
                        if (w_out_free) begin
                            w_out_valid_next = 1'b0;
                            w_out_inst_next  = NOP_INST;
                        end else begin
                            w_out_valid_next = r_out_valid;
                        end
                    end
                end
                ST_BLOCKED: begin
                    if (w_out_free) begin
                        w_out_valid_next = w_skid_full;
                        w_out_inst_next  = w_skid_full ? w_skid_inst : NOP_INST;
                        w_out_pc_next    = w_skid_pc;
                        w_skid_drain     = 1'b1;
                        w_state_next     = ST_REQ;
                        w_stb_next       = 1'b1;
                        w_iaddr_next     = r_pc;
                    end else begin
                        w_state_next = ST_BLOCKED;
                    end
                end
                ST_DISCARD: begin
                    if (w_ack) begin
                        if (is_misaligned(r_pc)) begin
                            w_state_next     = ST_FAULT;
                            w_stb_next       = 1'b0;
                            w_out_valid_next = 1'b1;
                            w_out_mis_next   = 1'b1;
                            w_out_pc_next    = r_pc;
                            w_out_inst_next  = NOP_INST;
                        end else begin
                            w_state_next = ST_REQ;
                            w_stb_next   = 1'b1;
                            w_iaddr_next = r_pc;
                        end
                    end else begin
                        w_state_next = ST_DISCARD;
                    end
                end
                ST_FAULT: begin
                    // Parked until the next redirect; the fault stays presented.
                    w_state_next = ST_FAULT;
                end
                default: begin
                    w_state_next     = ST_REQ;
                    w_stb_next       = 1'b0;
                    w_out_valid_next = 1'b0;
                    w_out_inst_next  = NOP_INST;
                    w_out_mis_next   = 1'b0;
                    w_skid_clear     = 1'b1;
                end
            endcase
        end
    end

    assign bus.o_iaddr      = r_iaddr;
    assign bus.o_stb_inst   = r_stb;
    assign bus.o_valid      = r_out_valid;
    assign bus.o_inst       = r_out_inst;
    assign bus.o_pc         = r_out_pc;
    assign bus.o_misaligned = r_out_mis;

endmodule
